// File: rtl/pipelined_control_unit.sv
// pipelined_control_unit: RV32I decoder carrying per-instruction control through D/E, E/M and M/W, resolving branches in E.
module pipelined_control_unit #(
  parameter int REG_ADDR_W = 5,
  parameter bit X0_WR_SUPPRESS = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [31:0]           instr_d,
  input  logic                  stall_d,
  input  logic                  zero_e,
  input  logic                  lt_e,
  input  logic                  ltu_e,
  output logic [2:0]            imm_src_d,
  output logic                  illegal_d,
  output logic [3:0]            alu_control_e,
  output logic                  alu_src_a_e,
  output logic                  alu_src_b_e,
  output logic [1:0]            pc_src_e,
  output logic                  flush_e,
  output logic [REG_ADDR_W-1:0] rd_e,
  output logic [REG_ADDR_W-1:0] rd_m,
  output logic [REG_ADDR_W-1:0] rd_w,
  output logic                  mem_wr_en_m,
  output logic                  mem_rd_en_m,
  output logic [2:0]            mem_size_m,
  output logic                  reg_wr_en_m,
  output logic                  reg_wr_en_w,
  output logic [1:0]            result_src_w
);
  localparam int NREG = 1 << REG_ADDR_W;
  typedef struct packed {
    logic                  valid;
    logic                  reg_wr_en;
    logic [1:0]            result_src;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [2:0]            mem_size;
    logic [3:0]            alu_control;
    logic                  alu_src_a;
    logic                  alu_src_b;
    logic                  branch;
    logic                  jal;
    logic                  jalr;
    logic [2:0]            funct3;
    logic [REG_ADDR_W-1:0] rd;
  } de_t;
  typedef struct packed {
    logic                  valid;
    logic                  reg_wr_en;
    logic [1:0]            result_src;
    logic                  mem_wr_en;
    logic                  mem_rd_en;
    logic [2:0]            mem_size;
    logic [REG_ADDR_W-1:0] rd;
  } em_t;
  typedef struct packed {
    logic                  valid;
    logic                  reg_wr_en;
    logic [1:0]            result_src;
    logic [REG_ADDR_W-1:0] rd;
  } mw_t;
  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd_f, rs1_f, rs2_f;
  logic is_r, is_i, is_ld, is_st, is_br, is_jal, is_jalr, is_lui, is_auipc;
  logic has_rd, has_rs1, has_rs2, r_bad, sh_bad, br_bad, reg_bad, alt;
  logic [3:0] f3_alu;
  logic cond, taken;
  de_t dec, de;
  em_t em;
  mw_t mw;
  assign opcode   = instr_d[6:0];
  assign funct3   = instr_d[14:12];
  assign funct7   = instr_d[31:25];
  assign rd_f     = instr_d[11:7];
  assign rs1_f    = instr_d[19:15];
  assign rs2_f    = instr_d[24:20];
  assign is_r     = opcode == 7'b0110011;
  assign is_i     = opcode == 7'b0010011;
  assign is_ld    = opcode == 7'b0000011;
  assign is_st    = opcode == 7'b0100011;
  assign is_br    = opcode == 7'b1100011;
  assign is_jal   = opcode == 7'b1101111;
  assign is_jalr  = opcode == 7'b1100111;
  assign is_lui   = opcode == 7'b0110111;
  assign is_auipc = opcode == 7'b0010111;
  assign has_rd   = is_r | is_i | is_ld | is_jal | is_jalr | is_lui | is_auipc;
  assign has_rs1  = is_r | is_i | is_ld | is_st | is_br | is_jalr;
  assign has_rs2  = is_r | is_st | is_br;
  // Register fields beyond the architectural file (RV32E) are undecodable.
  assign reg_bad  = (has_rd && int'(rd_f) >= NREG) || (has_rs1 && int'(rs1_f) >= NREG) ||
                    (has_rs2 && int'(rs2_f) >= NREG);
  assign r_bad    = is_r && (((funct7 & ~7'h20) != 7'h00) || (funct7[5] && funct3 != 3'd0 && funct3 != 3'd5));
  assign sh_bad   = is_i && ((funct3 == 3'd1 && funct7 != 7'h00) ||
                    (funct3 == 3'd5 && funct7 != 7'h00 && funct7 != 7'h20));
  assign br_bad   = is_br && funct3[2:1] == 2'b01;
  assign illegal_d = !(has_rd | is_st | is_br) | r_bad | sh_bad | br_bad | reg_bad;
  assign alt = is_r ? funct7[5] : (funct3 == 3'd5 && funct7[5]);
  always_comb begin
    f3_alu = 4'd0;
    case (funct3)
      3'd0: f3_alu = alt ? 4'd1 : 4'd0;
      3'd1: f3_alu = 4'd7;
      3'd2: f3_alu = 4'd5;
      3'd3: f3_alu = 4'd6;
      3'd4: f3_alu = 4'd4;
      3'd5: f3_alu = alt ? 4'd9 : 4'd8;
      3'd6: f3_alu = 4'd3;
      default: f3_alu = 4'd2;
    endcase
  end
  always_comb begin
    dec = '0;
    imm_src_d = 3'b000;
    if (!illegal_d) begin
      imm_src_d = is_st ? 3'b001 : is_br ? 3'b010 : is_jal ? 3'b011 : (is_lui | is_auipc) ? 3'b100 : 3'b000;
      dec.valid       = 1'b1;
      dec.reg_wr_en   = has_rd && !(X0_WR_SUPPRESS && rd_f == 5'd0);
      dec.result_src  = is_ld ? 2'b01 : (is_jal | is_jalr) ? 2'b10 : 2'b00;
      dec.mem_wr_en   = is_st;
      dec.mem_rd_en   = is_ld;
      dec.mem_size    = (is_ld | is_st) ? funct3 : 3'd0;
      dec.alu_control = (is_r | is_i) ? f3_alu : is_br ? 4'd1 : is_lui ? 4'd10 : 4'd0;
      dec.alu_src_a   = is_jal | is_auipc;
      dec.alu_src_b   = !(is_r | is_br);
      dec.branch      = is_br;
      dec.jal         = is_jal;
      dec.jalr        = is_jalr;
      dec.funct3      = funct3;
      dec.rd          = has_rd ? rd_f[REG_ADDR_W-1:0] : '0;
    end
  end
  // funct3[2:1] picks the flag, funct3[0] inverts it.
  assign cond  = de.funct3[2] ? (de.funct3[1] ? ltu_e : lt_e) : zero_e;
  assign taken = de.branch & (cond ^ de.funct3[0]);
  assign pc_src_e = !de.valid ? 2'b00 : de.jalr ? 2'b10 : (de.jal | taken) ? 2'b01 : 2'b00;
  assign flush_e  = pc_src_e != 2'b00;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      de <= '0;
      em <= '0;
      mw <= '0;
    end else begin
      de <= (flush_e || stall_d) ? '0 : dec;
      em <= '{valid: de.valid, reg_wr_en: de.reg_wr_en, result_src: de.result_src,
              mem_wr_en: de.mem_wr_en, mem_rd_en: de.mem_rd_en, mem_size: de.mem_size, rd: de.rd};
      mw <= '{valid: em.valid, reg_wr_en: em.reg_wr_en, result_src: em.result_src, rd: em.rd};
    end
  end
  assign alu_control_e = de.alu_control;
  assign alu_src_a_e   = de.alu_src_a;
  assign alu_src_b_e   = de.alu_src_b;
  assign rd_e          = de.rd;
  assign mem_wr_en_m   = em.valid & em.mem_wr_en;
  assign mem_rd_en_m   = em.valid & em.mem_rd_en;
  assign mem_size_m    = em.mem_size;
  assign reg_wr_en_m   = em.valid & em.reg_wr_en;
  assign rd_m          = em.rd;
  assign reg_wr_en_w   = mw.valid & mw.reg_wr_en;
  assign result_src_w  = mw.result_src;
  assign rd_w          = mw.rd;
endmodule

// File: tb/tb_pipelined_control_unit.sv
// tb_pipelined_control_unit: directed vector table plus multi-cycle stall/flush/reset sequences.
module tb_pipelined_control_unit;
  logic clk = 1'b0;
  logic rst_n, stall_d, zero_e, lt_e, ltu_e;
  logic [31:0] instr_d;
  logic [2:0] imm_src_d, mem_size_m;
  logic illegal_d, alu_src_a_e, alu_src_b_e, flush_e;
  logic mem_wr_en_m, mem_rd_en_m, reg_wr_en_m, reg_wr_en_w;
  logic [3:0] alu_control_e;
  logic [1:0] pc_src_e, result_src_w;
  logic [4:0] rd_e, rd_m, rd_w;
  int checks = 0;
  int failures = 0;
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [31:0] ADD = 32'h002081B3;
  localparam logic [31:0] BNE = 32'h00209463;
  localparam logic [31:0] BEQ = 32'h00208463;
  localparam logic [31:0] LW  = 32'h00412183;
  pipelined_control_unit dut (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .stall_d(stall_d),
    .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e), .imm_src_d(imm_src_d),
    .illegal_d(illegal_d), .alu_control_e(alu_control_e), .alu_src_a_e(alu_src_a_e),
    .alu_src_b_e(alu_src_b_e), .pc_src_e(pc_src_e), .flush_e(flush_e),
    .rd_e(rd_e), .rd_m(rd_m), .rd_w(rd_w), .mem_wr_en_m(mem_wr_en_m),
    .mem_rd_en_m(mem_rd_en_m), .mem_size_m(mem_size_m), .reg_wr_en_m(reg_wr_en_m),
    .reg_wr_en_w(reg_wr_en_w), .result_src_w(result_src_w)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [31:0] instr;
    logic [2:0]  flg;
    logic        ill;
    logic [2:0]  imm;
    logic [3:0]  alu;
    logic [1:0]  src;
    logic [1:0]  pc;
    logic [3:0]  en;
    logic [2:0]  sz;
    logic [1:0]  rs;
    logic [4:0]  rd;
  } vec_t;
  vec_t vecs[26];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    // flg = {zero, lt, ltu}; src = {a, b}; en = {flush, mem_wr, mem_rd, reg_wr}
    vecs[0]  = '{32'h002081B3, 3'b000, 1'b0, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd3};
    vecs[1]  = '{32'h407302B3, 3'b000, 1'b0, 3'd0, 4'd1,  2'b00, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd5};
    vecs[2]  = '{32'h4020D233, 3'b000, 1'b0, 3'd0, 4'd9,  2'b00, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd4};
    vecs[3]  = '{32'h003130B3, 3'b000, 1'b0, 3'd0, 4'd6,  2'b00, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd1};
    vecs[4]  = '{32'h00100013, 3'b000, 1'b0, 3'd0, 4'd0,  2'b01, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[5]  = '{32'h4030D313, 3'b000, 1'b0, 3'd0, 4'd9,  2'b01, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd6};
    vecs[6]  = '{32'hFFF0C113, 3'b000, 1'b0, 3'd0, 4'd4,  2'b01, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd2};
    vecs[7]  = '{32'h00412183, 3'b000, 1'b0, 3'd0, 4'd0,  2'b01, 2'd0, 4'b0011, 3'd2, 2'd1, 5'd3};
    vecs[8]  = '{32'h00512423, 3'b000, 1'b0, 3'd1, 4'd0,  2'b01, 2'd0, 4'b0100, 3'd2, 2'd0, 5'd0};
    vecs[9]  = '{32'h00209463, 3'b000, 1'b0, 3'd2, 4'd1,  2'b00, 2'd1, 4'b1000, 3'd0, 2'd0, 5'd0};
    vecs[10] = '{32'h00209463, 3'b100, 1'b0, 3'd2, 4'd1,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[11] = '{32'h0020C463, 3'b010, 1'b0, 3'd2, 4'd1,  2'b00, 2'd1, 4'b1000, 3'd0, 2'd0, 5'd0};
    vecs[12] = '{32'h0020F463, 3'b001, 1'b0, 3'd2, 4'd1,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[13] = '{32'h0020D463, 3'b000, 1'b0, 3'd2, 4'd1,  2'b00, 2'd1, 4'b1000, 3'd0, 2'd0, 5'd0};
    vecs[14] = '{32'h010000EF, 3'b000, 1'b0, 3'd3, 4'd0,  2'b11, 2'd1, 4'b1001, 3'd0, 2'd2, 5'd1};
    vecs[15] = '{32'h000280E7, 3'b000, 1'b0, 3'd0, 4'd0,  2'b01, 2'd2, 4'b1001, 3'd0, 2'd2, 5'd1};
    vecs[16] = '{32'h123453B7, 3'b000, 1'b0, 3'd4, 4'd10, 2'b01, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd7};
    vecs[17] = '{32'h00001417, 3'b000, 1'b0, 3'd4, 4'd0,  2'b11, 2'd0, 4'b0001, 3'd0, 2'd0, 5'd8};
    vecs[18] = '{32'h0000007F, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[19] = '{32'h0020A463, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[20] = '{32'h0230D313, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[21] = '{32'h022081B3, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[22] = '{32'h4020F1B3, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[23] = '{32'h40309313, 3'b000, 1'b1, 3'd0, 4'd0,  2'b00, 2'd0, 4'b0000, 3'd0, 2'd0, 5'd0};
    vecs[24] = '{32'h00208463, 3'b100, 1'b0, 3'd2, 4'd1,  2'b00, 2'd1, 4'b1000, 3'd0, 2'd0, 5'd0};
    vecs[25] = '{32'h0020E463, 3'b001, 1'b0, 3'd2, 4'd1,  2'b00, 2'd1, 4'b1000, 3'd0, 2'd0, 5'd0};
    rst_n = 1'b0; stall_d = 1'b0; zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0; instr_d = ADD;
    step();
    step();
    chk("rst_rd_e", rd_e, 0);
    chk("rst_pc_src", pc_src_e, 0);
    chk("rst_flush", flush_e, 0);
    chk("rst_wr_m", {mem_wr_en_m, mem_rd_en_m, reg_wr_en_m}, 0);
    chk("rst_wr_w", reg_wr_en_w, 0);
    rst_n = 1'b1;
    step();
    chk("rel_rd_e", rd_e, 3);
    chk("rel_w_c1", reg_wr_en_w, 0);
    instr_d = NOP;
    step();
    chk("rel_w_c2", reg_wr_en_w, 0);
    chk("rel_m_c2", reg_wr_en_m, 1);
    step();
    chk("rel_w_c3", reg_wr_en_w, 1);
    chk("rel_rd_w", rd_w, 3);
    for (int i = 0; i < 26; i++) begin
      instr_d = vecs[i].instr;
      {zero_e, lt_e, ltu_e} = vecs[i].flg;
      #1;
      chk($sformatf("v%0d_illegal", i), illegal_d, vecs[i].ill);
      chk($sformatf("v%0d_imm_src", i), imm_src_d, vecs[i].imm);
      step();
      chk($sformatf("v%0d_alu", i), alu_control_e, vecs[i].alu);
      chk($sformatf("v%0d_src", i), {alu_src_a_e, alu_src_b_e}, vecs[i].src);
      chk($sformatf("v%0d_pc_src", i), pc_src_e, vecs[i].pc);
      chk($sformatf("v%0d_flush", i), flush_e, vecs[i].en[3]);
      chk($sformatf("v%0d_rd_e", i), rd_e, vecs[i].rd);
      instr_d = NOP;
      step();
      chk($sformatf("v%0d_mem", i), {mem_wr_en_m, mem_rd_en_m}, vecs[i].en[2:1]);
      chk($sformatf("v%0d_size", i), mem_size_m, vecs[i].sz);
      chk($sformatf("v%0d_wr_m", i), reg_wr_en_m, vecs[i].en[0]);
      chk($sformatf("v%0d_rd_m", i), rd_m, vecs[i].rd);
      step();
      chk($sformatf("v%0d_wr_w", i), reg_wr_en_w, vecs[i].en[0]);
      chk($sformatf("v%0d_res_w", i), result_src_w, vecs[i].rs);
      chk($sformatf("v%0d_rd_w", i), rd_w, vecs[i].rd);
    end
    // taken BNE squashes the instruction behind it
    {zero_e, lt_e, ltu_e} = 3'b000; instr_d = BNE;
    step();
    chk("bne_pc_src", pc_src_e, 1);
    chk("bne_flush", flush_e, 1);
    instr_d = ADD;
    step();
    chk("bne_bubble_rd", rd_e, 0);
    chk("bne_bubble_flush", flush_e, 0);
    instr_d = NOP;
    step();
    chk("bne_bubble_m", reg_wr_en_m, 0);
    // stalled load: one bubble, then the load flows through
    instr_d = LW; stall_d = 1'b1;
    step();
    chk("lw_stall_rd_e", rd_e, 0);
    chk("lw_stall_src_b", alu_src_b_e, 0);
    stall_d = 1'b0;
    step();
    chk("lw_rd_e", rd_e, 3);
    chk("lw_src_b", alu_src_b_e, 1);
    instr_d = NOP;
    step();
    chk("lw_rd_en_m", mem_rd_en_m, 1);
    chk("lw_size_m", mem_size_m, 2);
    chk("lw_rd_m", rd_m, 3);
    step();
    chk("lw_res_w", result_src_w, 1);
    chk("lw_rd_w", rd_w, 3);
    chk("lw_wr_w", reg_wr_en_w, 1);
    // stall coincident with a taken BEQ in E
    zero_e = 1'b1; instr_d = BEQ;
    step();
    instr_d = ADD; stall_d = 1'b1;
    #1;
    chk("beq_stall_flush", flush_e, 1);
    chk("beq_stall_pc", pc_src_e, 1);
    step();
    chk("beq_bubble_rd", rd_e, 0);
    chk("beq_bubble_flush", flush_e, 0);
    stall_d = 1'b0; instr_d = NOP;
    step();
    chk("beq_after_rd_e", rd_e, 0);
    chk("beq_after_wr_m", reg_wr_en_m, 0);
    step();
    chk("beq_after_wr_w", reg_wr_en_w, 0);
    chk("beq_after_rd_m", rd_m, 0);
    // reset mid-pipeline discards in-flight work
    zero_e = 1'b0; instr_d = ADD;
    step();
    step();
    rst_n = 1'b0;
    step();
    chk("mid_rst_rd_e", rd_e, 0);
    chk("mid_rst_wr_m", reg_wr_en_m, 0);
    chk("mid_rst_wr_w", reg_wr_en_w, 0);
    chk("mid_rst_rd_w", rd_w, 0);
    rst_n = 1'b1; instr_d = NOP;
    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
